// File: rtl/dccm_arb_pkg.sv
// Shared types and constants for the DCCM arbiter slice.
// Request fields are sized for the default 32-bit data / 16-bit address build.
package dccm_arb_pkg;

  localparam int STARVE_CNT_W = 4;
  localparam int DCCM_XLEN    = 32;
  localparam int DCCM_AW      = 16;

  typedef enum logic {ARB_LSU_PRIO, ARB_DMA_FORCE} arb_state_e;
  typedef enum logic {OWN_LSU, OWN_DMA} arb_owner_e;

  typedef struct packed {
    logic                   we;
    logic [DCCM_AW-1:0]     addr;
    logic [DCCM_XLEN-1:0]   wdata;
    logic [DCCM_XLEN/8-1:0] wmask;
  } dccm_req_t;

  // Reads must never present byte enables to the macro.
  function automatic dccm_req_t req_gate(input dccm_req_t r);
    dccm_req_t g;
    g = r;
    if (!r.we) g.wmask = '0;
    return g;
  endfunction

endpackage

// File: rtl/dccm_rsp_router.sv
// Tracks the owner of the last accepted read and steers the
// one-cycle-latency DCCM read data back to that requester.
module dccm_rsp_router
  import dccm_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_acc,
  input  arb_owner_e      rd_owner,
  input  logic [XLEN-1:0] dccm_rdata,
  output logic            lsu_rsp_valid,
  output logic [XLEN-1:0] lsu_rsp_rdata,
  output logic            dma_rsp_valid,
  output logic [XLEN-1:0] dma_rsp_rdata
);

  logic       rsp_pend_q;
  arb_owner_e rsp_owner_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWN_LSU;
    end else begin
      rsp_pend_q  <= rd_acc;
      rsp_owner_q <= rd_owner;
    end
  end

  // Gating with rst_n drops a response whose read was accepted just before reset.
  assign lsu_rsp_valid = rst_n & rsp_pend_q & (rsp_owner_q == OWN_LSU);
  assign dma_rsp_valid = rst_n & rsp_pend_q & (rsp_owner_q == OWN_DMA);

  assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rdata : '0;
  assign dma_rsp_rdata = dma_rsp_valid ? dccm_rdata : '0;

endmodule

// File: rtl/dccm_arbiter.sv
// Single-port DCCM arbiter: LSU fixed priority with a starvation escape
// that forces one DMA grant after STARVE_LIMIT consecutive LSU wins.
//
// state         | meaning
// --------------+-------------------------------------------
// ARB_LSU_PRIO  | LSU wins any conflict (reset state)
// ARB_DMA_FORCE | DMA wins the conflict for one acceptance
module dccm_arbiter
  import dccm_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DCCM_ADDR_W  = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_we,
  input  logic [DCCM_ADDR_W-1:0] lsu_req_addr,
  input  logic [XLEN-1:0]        lsu_req_wdata,
  input  logic [XLEN/8-1:0]      lsu_req_wmask,
  output logic                   lsu_rsp_valid,
  output logic [XLEN-1:0]        lsu_rsp_rdata,

  input  logic                   dma_req_valid,
  output logic                   dma_req_ready,
  input  logic                   dma_req_we,
  input  logic [DCCM_ADDR_W-1:0] dma_req_addr,
  input  logic [XLEN-1:0]        dma_req_wdata,
  input  logic [XLEN/8-1:0]      dma_req_wmask,
  output logic                   dma_rsp_valid,
  output logic [XLEN-1:0]        dma_rsp_rdata,

  output logic                   dccm_en,
  output logic                   dccm_we,
  output logic [DCCM_ADDR_W-1:0] dccm_addr,
  output logic [XLEN-1:0]        dccm_wdata,
  output logic [XLEN/8-1:0]      dccm_wmask,
  input  logic [XLEN-1:0]        dccm_rdata,

  output logic [15:0]            starve_events
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [15:0]             starve_events_q;
  logic                    lsu_gnt, dma_gnt;
  dccm_req_t               lsu_req, dma_req, gnt_req;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_LSU_PRIO;
    else        state_q <= state_d;
  end

  // FSM: next state. Switching on the edge where the count reaches the
  // limit lets DMA win the very next cycle after STARVE_LIMIT LSU wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_LSU_PRIO:
        if (dma_req_valid && (starve_cnt_d == LIMIT)) state_d = ARB_DMA_FORCE;
      ARB_DMA_FORCE:
        if (dma_gnt || !dma_req_valid) state_d = ARB_LSU_PRIO;
      default:
        state_d = ARB_LSU_PRIO;
    endcase
  end

  // FSM: outputs (grants)
  always_comb begin
    lsu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        ARB_DMA_FORCE: begin
          dma_gnt = dma_req_valid;
          lsu_gnt = lsu_req_valid & ~dma_req_valid;
        end
        default: begin
          lsu_gnt = lsu_req_valid;
          dma_gnt = dma_req_valid & ~lsu_req_valid;
        end
      endcase
    end
  end

  assign lsu_req_ready = lsu_gnt;
  assign dma_req_ready = dma_gnt;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_gnt || !dma_req_valid)
      starve_cnt_d = '0;
    else if (lsu_gnt && (starve_cnt_q != '1))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q    <= '0;
      starve_events_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (dma_gnt && (state_q == ARB_DMA_FORCE) && lsu_req_valid &&
          (starve_events_q != 16'hFFFF))
        starve_events_q <= starve_events_q + 16'd1;
    end
  end

  assign starve_events = starve_events_q;

  assign lsu_req = '{we: lsu_req_we, addr: lsu_req_addr,
                     wdata: lsu_req_wdata, wmask: lsu_req_wmask};
  assign dma_req = '{we: dma_req_we, addr: dma_req_addr,
                     wdata: dma_req_wdata, wmask: dma_req_wmask};

  always_comb begin
    gnt_req = '0;
    if (lsu_gnt)      gnt_req = req_gate(lsu_req);
    else if (dma_gnt) gnt_req = req_gate(dma_req);
  end

  assign dccm_en    = lsu_gnt | dma_gnt;
  assign dccm_we    = gnt_req.we;
  assign dccm_addr  = gnt_req.addr;
  assign dccm_wdata = gnt_req.wdata;
  assign dccm_wmask = gnt_req.wmask;

  dccm_rsp_router #(
    .XLEN (XLEN)
  ) u_rsp_router (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_acc        (dccm_en & ~dccm_we),
    .rd_owner      (dma_gnt ? OWN_DMA : OWN_LSU),
    .dccm_rdata    (dccm_rdata),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .dma_rsp_valid (dma_rsp_valid),
    .dma_rsp_rdata (dma_rsp_rdata)
  );

endmodule
